// File: rtl/prop_mon_pkg.sv
// prop_mon_pkg: shared types and constants for the multi-channel property monitor.
//   err_code_e  : code reported in the first-error capture
//   mon_state_e : arm/trip state of the monitor
//   *_BIT       : position of each rule inside a channel's 3-bit fail vector
package prop_mon_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SUM    = 2'd1,
        ERR_EQ     = 2'd2,
        ERR_ONEHOT = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        TRIPPED  = 2'd2
    } mon_state_e;

    localparam int SUM_BIT   = 0;
    localparam int EQ_BIT    = 1;
    localparam int OH_BIT    = 2;
    localparam int NUM_RULES = 3;

    // Highest-priority rule among a channel's fail bits: SUM > EQ > ONEHOT.
    function automatic err_code_e fail_to_code(input logic [NUM_RULES-1:0] fail);
        if (fail[SUM_BIT])     return ERR_SUM;
        else if (fail[EQ_BIT]) return ERR_EQ;
        else if (fail[OH_BIT]) return ERR_ONEHOT;
        else                   return ERR_NONE;
    endfunction

endpackage

// File: rtl/prop_monitor_multi_chan.sv
// prop_mon_chan: one monitored channel, two register stages.
//   Stage 1 registers a+1 (modulo 2^WIDTH), a==b, !onehot(a) and the sample qualifier.
//   Stage 2 registers the qualified 3-bit fail vector {onehot, eq, sum}.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sample        : channel valid already gated by the monitor's armed state
//   a, b          : operands
//   fail          : registered qualified fail vector (bit positions from prop_mon_pkg)
// Optional macro PROP_MON_SVA_EN adds concurrent assertions on each rule; the
// reporting path (%m) contains the generate index of the channel.
module prop_mon_chan
    import prop_mon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [NUM_RULES-1:0] fail
);

    // Compare on 33 bits so LIMIT above 2^WIDTH can never be reached and
    // LIMIT = 0 always trips, without any special casing.
    localparam logic [32:0] LIMIT_EXT = 33'(LIMIT);

    logic [WIDTH-1:0]     sum_reg;
    logic                 valid_reg;
    logic                 eq_reg;
    logic                 oh_reg;
    logic [NUM_RULES-1:0] fail_reg;
    logic                 a_onehot;
    logic                 sum_fail;

    // Zero is not one-hot, so it fails the rule.
    assign a_onehot = (a != '0) && ((a & (a - WIDTH'(1))) == '0);
    assign sum_fail = 33'(sum_reg) >= LIMIT_EXT;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= '0;
            valid_reg <= 1'b0;
            eq_reg    <= 1'b0;
            oh_reg    <= 1'b0;
            fail_reg  <= '0;
        end else begin
            sum_reg   <= a + WIDTH'(1);
            valid_reg <= sample;
            eq_reg    <= (a == b);
            oh_reg    <= !a_onehot;
            fail_reg[SUM_BIT] <= valid_reg & sum_fail;
            fail_reg[EQ_BIT]  <= valid_reg & eq_reg;
            fail_reg[OH_BIT]  <= valid_reg & oh_reg;
        end
    end

    assign fail = fail_reg;

`ifdef PROP_MON_SVA_EN
    a_sum_bound: assert property (@(posedge clk) disable iff (rst) valid_reg |-> !sum_fail)
        else $error("sum bound violated on channel %m: sum=%0d", sum_reg);
    a_neq: assert property (@(posedge clk) disable iff (rst) valid_reg |-> !eq_reg)
        else $error("operand equality on channel %m");
    a_onehot_a: assert property (@(posedge clk) disable iff (rst) valid_reg |-> !oh_reg)
        else $error("operand a not one-hot on channel %m");
`else
    // Assertions excluded from this build; datapath is identical.
`endif

endmodule

// File: rtl/prop_monitor_multi.sv
// prop_monitor_multi: multi-channel run-time property monitor.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (highest priority)
//   en              : arm request
//   clear           : clears sticky flags, counter and capture; re-arms if en
//   chan_valid      : per-channel sample qualifier
//   a, b            : packed operands, channel i at [i*WIDTH +: WIDTH]
//   err_sticky      : per channel {onehot, eq, sum} sticky flags
//   err_count       : saturating total of violations
//   first_err_*     : capture of the first violation (lowest channel, then SUM>EQ>ONEHOT)
//   irq             : high while the monitor is TRIPPED
// Optional macro PROP_MON_SVA_EN enables per-channel assertions in prop_mon_chan.
module prop_monitor_multi
    import prop_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int LIMIT    = 12,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clear,
    input  logic [CHANNELS-1:0]         chan_valid,
    input  logic [CHANNELS*WIDTH-1:0]   a,
    input  logic [CHANNELS*WIDTH-1:0]   b,
    output logic [CHANNELS*3-1:0]       err_sticky,
    output logic [CNT_W-1:0]            err_count,
    output logic                        first_err_valid,
    output logic [CH_W-1:0]             first_err_chan,
    output logic [1:0]                  first_err_code,
    output logic                        irq
);

    localparam int SUM_W = $clog2(NUM_RULES*CHANNELS + 1);

    mon_state_e                  state_reg;
    logic [CHANNELS*3-1:0]       sticky_reg;
    logic [CNT_W-1:0]            count_reg;
    logic                        fv_reg;
    logic [CH_W-1:0]             fchan_reg;
    err_code_e                   fcode_reg;

    logic                        armed;
    logic [CHANNELS*3-1:0]       fail_vec;
    logic                        any_fail;
    logic [SUM_W-1:0]            fail_cnt;
    logic [CNT_W:0]              count_sum;
    logic [CH_W-1:0]             fchan_next;
    err_code_e                   fcode_next;

    // Samples taken while DISARMED are dropped at stage 1.
    assign armed = (state_reg != DISARMED);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            prop_mon_chan #(
                .WIDTH (WIDTH),
                .LIMIT (LIMIT)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .sample (chan_valid[gi] & armed),
                .a      (a[gi*WIDTH +: WIDTH]),
                .b      (b[gi*WIDTH +: WIDTH]),
                .fail   (fail_vec[gi*NUM_RULES +: NUM_RULES])
            );
        end
    endgenerate

    assign any_fail = |fail_vec;

    always_comb begin
        fail_cnt = '0;
        for (int i = 0; i < CHANNELS*NUM_RULES; i++) begin
            fail_cnt = fail_cnt + SUM_W'(fail_vec[i]);
        end
    end

    // One extra bit catches the carry out so the counter saturates instead of wrapping.
    assign count_sum = {1'b0, count_reg} + (CNT_W+1)'(fail_cnt);

    // Lowest failing channel wins; the package function orders rules inside it.
    always_comb begin
        logic found;
        found      = 1'b0;
        fchan_next = '0;
        fcode_next = ERR_NONE;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && |fail_vec[i*NUM_RULES +: NUM_RULES]) begin
                found      = 1'b1;
                fchan_next = CH_W'(i);
                fcode_next = fail_to_code(fail_vec[i*NUM_RULES +: NUM_RULES]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= DISARMED;
            sticky_reg <= '0;
            count_reg  <= '0;
            fv_reg     <= 1'b0;
            fchan_reg  <= '0;
            fcode_reg  <= ERR_NONE;
        end else begin
            case (state_reg)
                DISARMED: if (en) state_reg <= ARMED;
                ARMED: begin
                    // clear discards same-cycle violations, so it wins over tripping.
                    if (clear)         state_reg <= en ? ARMED : DISARMED;
                    else if (any_fail) state_reg <= TRIPPED;
                    else if (!en)      state_reg <= DISARMED;
                end
                TRIPPED:  if (clear) state_reg <= en ? ARMED : DISARMED;
                default:  state_reg <= DISARMED;
            endcase

            if (clear) begin
                sticky_reg <= '0;
                count_reg  <= '0;
                fv_reg     <= 1'b0;
                fchan_reg  <= '0;
                fcode_reg  <= ERR_NONE;
            end else begin
                sticky_reg <= sticky_reg | fail_vec;
                count_reg  <= count_sum[CNT_W] ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
                if (!fv_reg && any_fail) begin
                    fv_reg    <= 1'b1;
                    fchan_reg <= fchan_next;
                    fcode_reg <= fcode_next;
                end
            end
        end
    end

    assign err_sticky      = sticky_reg;
    assign err_count       = count_reg;
    assign first_err_valid = fv_reg;
    assign first_err_chan  = fchan_reg;
    assign first_err_code  = fcode_reg;
    assign irq             = (state_reg == TRIPPED);

endmodule

// File: tb/tb_prop_monitor_multi.sv
// Scoreboard bench for prop_monitor_multi (default parameters: WIDTH=8,
// CHANNELS=4, LIMIT=12, CNT_W=16). Stimulus pushes the hand-computed status
// expected at a given cycle; the monitor pops and compares on the falling edge.
module tb_prop_monitor_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clear;
    logic [3:0]  chan_valid;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic [11:0] err_sticky;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [1:0]  first_err_chan;
    logic [1:0]  first_err_code;
    logic        irq;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          tgt;
        string       name;
        logic [11:0] sticky;
        logic [15:0] cnt;
        logic        fv;
        logic [1:0]  fch;
        logic [1:0]  fcode;
        logic        irq;
    } exp_t;

    exp_t sb[$];

    prop_monitor_multi dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .clear           (clear),
        .chan_valid      (chan_valid),
        .a               (a_bus),
        .b               (b_bus),
        .err_sticky      (err_sticky),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_chan  (first_err_chan),
        .first_err_code  (first_err_code),
        .irq             (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / comparator.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (e.tgt < cyc || err_sticky !== e.sticky || err_count !== e.cnt ||
                first_err_valid !== e.fv || first_err_chan !== e.fch ||
                first_err_code !== e.fcode || irq !== e.irq) begin
                miscompares++;
                $display("FAIL %s @%0d: sticky=%h want %h count=%0d want %0d fv=%b want %b chan=%0d want %0d code=%0d want %0d irq=%b want %b",
                         e.name, cyc, err_sticky, e.sticky, err_count, e.cnt, first_err_valid, e.fv,
                         first_err_chan, e.fch, first_err_code, e.fcode, irq, e.irq);
            end else begin
                $display("ok   %s @%0d: sticky=%h count=%0d fv=%b chan=%0d code=%0d irq=%b",
                         e.name, cyc, err_sticky, err_count, first_err_valid, first_err_chan,
                         first_err_code, irq);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int dly, input string nm, input logic [11:0] st,
                             input logic [15:0] c, input logic v, input logic [1:0] ch,
                             input logic [1:0] cd, input logic ir);
        exp_t e;
        e.tgt = cyc + dly; e.name = nm; e.sticky = st; e.cnt = c;
        e.fv = v; e.fch = ch; e.fcode = cd; e.irq = ir;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] av, input logic [31:0] bv);
        chan_valid = v;
        a_bus      = av;
        b_bus      = bv;
    endtask

    task automatic idle();
        drive(4'b0000, 32'h0, 32'h0);
    endtask

    task automatic do_clear(input string nm);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        expect_at(0, nm, 12'h000, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0;
        idle();
        tick(2);
        rst = 1'b0;
        expect_at(0, "reset", 12'h000, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);

        // Arm, then a clean sample on ch0.
        en = 1'b1;
        tick(1);
        drive(4'b0001, 32'h0000_0001, 32'h0000_0002);
        tick(1); idle();
        expect_at(2, "clean_ch0", 12'h000, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        tick(3);

        // ch2 a=0x10: sum 0x11 >= 12, one-hot, a!=b -> sum only (sticky bit 6).
        drive(4'b0100, 32'h0010_0000, 32'h0000_0000);
        tick(1); idle();
        expect_at(2, "sum_ch2", 12'h040, 16'd1, 1'b1, 2'd2, 2'd1, 1'b1);
        tick(3);
        do_clear("clear1");

        // ch1 a=b=4 (eq, bit 4) and ch3 a=3 (onehot, bit 11).
        drive(4'b1010, 32'h0300_0400, 32'h0000_0400);
        tick(1); idle();
        expect_at(2, "eq_ch1_oh_ch3", 12'h810, 16'd2, 1'b1, 2'd1, 2'd2, 1'b1);
        tick(3);
        do_clear("clear2");

        // ch0 a=b=0x0F: all three rules; ch2 a=0: onehot(0) fail -> 4 total, ch0 SUM first.
        drive(4'b0101, 32'h0000_000F, 32'h0001_000F);
        tick(1); idle();
        expect_at(2, "all3_ch0_zero_ch2", 12'h107, 16'd4, 1'b1, 2'd0, 2'd1, 1'b1);
        tick(3);
        do_clear("clear3");

        // ch1 a=0xFF: sum wraps to 0 (no fail), not one-hot (bit 5).
        drive(4'b0010, 32'h0000_FF00, 32'h0000_0000);
        tick(1); idle();
        expect_at(2, "wrap_ch1", 12'h020, 16'd1, 1'b1, 2'd1, 2'd3, 1'b1);
        tick(3);
        do_clear("clear4");

        // Disarmed: violating samples must not count.
        en = 1'b0;
        tick(1);
        drive(4'b0001, 32'h0000_000F, 32'h0000_000F);
        tick(1); idle();
        expect_at(2, "disarmed", 12'h000, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        tick(3);
        en = 1'b1;
        tick(1);

        // Clear coincides with V1 reaching the counters; V2 (ch3 sum, bit 9) counts next.
        drive(4'b0001, 32'h0000_0010, 32'h0000_0000);
        tick(1);
        drive(4'b1000, 32'h2000_0000, 32'h0000_0000);
        tick(1);
        idle();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        expect_at(0, "clear_wins", 12'h000, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        tick(1);
        expect_at(0, "inflight_counts", 12'h200, 16'd1, 1'b1, 2'd3, 2'd1, 1'b1);
        tick(2);
        do_clear("clear5");

        // 12 violations per sample on all channels: 10 samples -> 120.
        drive(4'b1111, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        tick(10); idle();
        expect_at(2, "burst120", 12'hFFF, 16'd120, 1'b1, 2'd0, 2'd1, 1'b1);
        tick(3);
        // 5470 samples in total -> 65640 > 65535, must saturate.
        drive(4'b1111, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        tick(5460); idle();
        expect_at(2, "saturate", 12'hFFF, 16'hFFFF, 1'b1, 2'd0, 2'd1, 1'b1);
        tick(3);

        // Reset while TRIPPED, then samples with en=0 stay silent.
        rst = 1'b1; en = 1'b0;
        tick(1);
        rst = 1'b0;
        expect_at(0, "rst_tripped", 12'h000, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        drive(4'b1111, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        tick(1); idle();
        expect_at(2, "post_rst_en0", 12'h000, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        tick(3);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations pending, want 0", sb.size());
            miscompares += sb.size();
            vectors += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
